fetch_queue: RTL and testbench

Instruction fetch stage for the RV32I core, directly upstream of the instruction decoder. It owns the fetch PC and issues word reads to instruction memory over a valid/ready request channel. It buffers returned instruction words with their PCs in a small FIFO and presents them to decode with a valid/ready handshake. On a taken jump or branch redirect it flushes the queue and discards stale in-flight responses.

---
 rtl/fetch_queue.sv | 133 +++++++++++++
 tb/tb_fetch_queue.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// RV32I instruction fetch stage: issues word reads against a credit budget and
// buffers returned words with their PCs for decode. Redirects flush the queue and drop stale responses.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] ins_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    cnt_t        count_q, count_d;
    cnt_t        inflight_q, inflight_d;
    cnt_t        drop_q, drop_d;
    logic [31:0] mem_pc_q   [DEPTH];
    logic [31:0] mem_pc_d   [DEPTH];
    logic [31:0] mem_word_q [DEPTH];
    logic [31:0] mem_word_d [DEPTH];

    logic [CW:0] used_s;
    logic        accept_s;
    logic        pop_s;
    logic        push_s;
    logic [31:0] target_s;

    // Outstanding requests plus buffered words may never exceed the FIFO size.
    assign used_s         = {1'b0, inflight_q} + {1'b0, count_q};
    assign imem_req_valid = rst_n && !redirect && (used_s < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign accept_s       = imem_req_valid && imem_req_ready;
    assign ins_valid      = (count_q != cnt_t'(0));
    assign ins            = mem_word_q[rd_ptr_q];
    assign ins_pc         = mem_pc_q[rd_ptr_q];
    assign pop_s          = ins_valid && ins_ready;
    assign push_s         = imem_rsp_valid && (drop_q == cnt_t'(0));
    assign target_s       = redirect_pc & 32'hFFFF_FFFC;

    // Next-state: redirect overrides every other update in its cycle.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        mem_pc_d   = mem_pc_q;
        mem_word_d = mem_word_q;
        if (redirect) begin
            fetch_pc_d = target_s;
            rsp_pc_d   = target_s;
            rd_ptr_d   = ptr_t'(0);
            wr_ptr_d   = ptr_t'(0);
            count_d    = cnt_t'(0);
            // Every request still outstanding after this cycle is stale.
            inflight_d = inflight_q - cnt_t'(imem_rsp_valid);
            drop_d     = inflight_q - cnt_t'(imem_rsp_valid);
        end else begin
            if (accept_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            inflight_d = inflight_q + cnt_t'(accept_s) - cnt_t'(imem_rsp_valid);
            if (imem_rsp_valid && (drop_q != cnt_t'(0))) begin
                drop_d = drop_q - cnt_t'(1);
            end else begin
                drop_d = drop_q;
            end
            if (push_s) begin
                mem_pc_d[wr_ptr_q]   = rsp_pc_q;
                mem_word_d[wr_ptr_q] = imem_rsp_data;
                wr_ptr_d             = wr_ptr_q + ptr_t'(1);
                rsp_pc_d             = rsp_pc_q + 32'd4;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + cnt_t'(push_s) - cnt_t'(pop_s);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            rd_ptr_q   <= ptr_t'(0);
            wr_ptr_q   <= ptr_t'(0);
            count_q    <= cnt_t'(0);
            inflight_q <= cnt_t'(0);
            drop_q     <= cnt_t'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]   <= 32'h0000_0000;
                mem_word_q[i] <= 32'h0000_0000;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            mem_pc_q   <= mem_pc_d;
            mem_word_q <= mem_word_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a latency-randomized memory model feeds the DUT
// while a queue-based reference of outstanding requests and buffered words predicts every output.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0000_0000;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0000_0000;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [31:0] ins;
    logic [31:0] ins_pc;

    fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins            (ins),
        .ins_pc         (ins_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] pc; logic stale; } out_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] w; } ent_t;

    out_t        outst[$];
    ent_t        fq[$];
    int          mem_due[$];
    logic [31:0] m_fetch_pc;
    int          cyc;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        redirect       = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        ins_ready      = 1'b1;
        #1;
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_ins_valid", 32'(ins_valid), 32'd0);
        check_eq("rst_ins", ins, 32'h0000_0000);
        check_eq("rst_ins_pc", ins_pc, 32'h0000_0000);
        outst.delete();
        fq.delete();
        mem_due.delete();
        m_fetch_pc = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic step(input int lat_max, input int p_rdy, input int p_ins, input int p_redir);
        logic        exp_valid;
        logic        rsp;
        logic [31:0] rdata;
        logic [31:0] rpc;
        out_t        o;
        @(negedge clk);
        rpc            = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'h0000_000F)) : $urandom;
        redirect       = ($urandom_range(99) < p_redir);
        redirect_pc    = rpc;
        imem_req_ready = ($urandom_range(99) < p_rdy);
        ins_ready      = ($urandom_range(99) < p_ins);
        rsp            = (mem_due.size() > 0) && (mem_due[0] <= cyc);
        rdata          = $urandom;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? rdata : 32'hDEAD_BEEF;
        #1;
        exp_valid = !redirect && ((outst.size() + fq.size()) < DEPTH);
        check_eq("req_valid", 32'(imem_req_valid), 32'(exp_valid));
        if (exp_valid) check_eq("req_addr", imem_req_addr, m_fetch_pc);
        check_eq("ins_valid", 32'(ins_valid), 32'(fq.size() != 0));
        if (fq.size() != 0) begin
            check_eq("ins_pc", ins_pc, fq[0].pc);
            check_eq("ins", ins, fq[0].w);
        end
        o = '{pc: 32'h0000_0000, stale: 1'b1};
        if (rsp) begin
            void'(mem_due.pop_front());
            if (outst.size() != 0) o = outst.pop_front();
        end
        if (redirect) begin
            foreach (outst[i]) outst[i].stale = 1'b1;
            fq.delete();
            m_fetch_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (fq.size() != 0 && ins_ready) void'(fq.pop_front());
            if (rsp && !o.stale) fq.push_back('{pc: o.pc, w: rdata});
            if (exp_valid && imem_req_ready) begin
                outst.push_back('{pc: m_fetch_pc, stale: 1'b0});
                m_fetch_pc = m_fetch_pc + 32'd4;
                mem_due.push_back(cyc + int'($urandom_range(lat_max, 1)));
            end
        end
        cyc++;
    endtask

    task automatic run(input int n, input int lat_max, input int p_rdy, input int p_ins, input int p_redir);
        for (int k = 0; k < n; k++) step(lat_max, p_rdy, p_ins, p_redir);
    endtask

    initial begin
        cyc = 0;
        do_reset();
        // Streaming with single-cycle memory and decode always ready.
        run(30, 1, 100, 100, 0);
        // Decode stalled long enough to saturate the queue, then drained.
        do_reset();
        run(12, 1, 100, 0, 0);
        run(12, 1, 100, 100, 0);
        // Longer memory latency with occasional redirects.
        run(200, 3, 100, 100, 5);
        // Memory and decode backpressure mixed with frequent redirects.
        run(300, 2, 60, 70, 8);
        run(300, 3, 50, 50, 12);
        // Reset in the middle of traffic, then recover.
        do_reset();
        run(200, 3, 70, 80, 6);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
